sevenseg_scanner: RTL and testbench

Time-multiplexing stage directly upstream of `sevensegdecoder_always`: holds a 16-bit hex value, scans it one nibble at a time onto the decoder's 4-bit `digit` input, and drives the matching active-low common anode of a 4-digit display. It provides a coherent load point, so a value cannot tear mid-scan, plus optional leading-zero blanking and an anti-ghosting blank gap at each digit change.

---
 rtl/sevenseg_pkg.sv | 22 ++
 rtl/refresh_prescaler.sv | 26 ++
 rtl/sevenseg_scanner.sv | 85 ++++++++
 tb/tb_sevenseg_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment display path.
// Both anodes and segments are active-low.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;

    // Level that turns a display element on.
    localparam logic LED_ON = 1'b0;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{~LED_ON}};

    typedef logic [1:0] pos_t;

    function automatic logic [NUM_DIGITS-1:0] anode_select(input pos_t p);
        logic [NUM_DIGITS-1:0] a;
        a    = ANODE_OFF;
        a[p] = LED_ON;
        return a;
    endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running slot timer: counts 0..DIV-1 and strobes wrap on the last count.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [$clog2(DIV)-1:0] count,
    output logic                   wrap
);

    localparam int CNT_W = $clog2(DIV);

    assign wrap = (count == CNT_W'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// Scans a shadowed 16-bit hex value one nibble per slot onto a 4-digit display,
// with optional leading-zero blanking and an anti-ghosting blank gap per slot.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [NIBBLE_W-1:0]   digit,
    output logic [NUM_DIGITS-1:0] anodes
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]   pcnt;
    logic               wrap;
    pos_t               pos;
    logic [VALUE_W-1:0] shadow;
    logic               in_gap;
    logic               lead_zero;
    logic [NIBBLE_W-1:0] digit_next;
    logic [NUM_DIGITS-1:0] anodes_next;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .count (pcnt),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pos    <= '0;
            shadow <= '0;
        end else begin
            if (wrap) begin
                pos <= pos + 2'd1;
            end
            if (load) begin
                shadow <= value;
            end
        end
    end

    // A zero-length gap would make the compare constant, so it is elided.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (pcnt < CNT_W'(BLANK_CYC));
        end
    endgenerate

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        lead_zero   = 1'b0;
        digit_next  = shadow[{pos, 2'b00} +: NIBBLE_W];
        anodes_next = anode_select(pos);
        if (blank_lz && (pos != '0)) begin
            lead_zero = ((shadow >> {pos, 2'b00}) == '0);
        end
        if (in_gap || lead_zero) begin
            anodes_next = ANODE_OFF;
        end
    end

    // Registered outputs keep the decoder input glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit  <= '0;
            anodes <= ANODE_OFF;
        end else begin
            digit  <= digit_next;
            anodes <= anodes_next;
        end
    end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with REFRESH_DIV=8 and BLANK_CYC=2.
module tb_sevenseg_scanner;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  anodes;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Lit anode pattern for positions 0..3.
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    sevenseg_scanner #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .digit    (digit),
        .anodes   (anodes)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // After this, edge_n=0 refers to the reset edge.
    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        tick();
        rst    = 1'b0;
        edge_n = 0;
    endtask

    // Load pulse sampled at the next edge (edge 1 when called right after reset).
    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        value    = 16'hFFFF;
        blank_lz = 1'b0;
        load     = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        edge_n = 0;
        checks++;
        if (anodes !== 4'hF) begin
            failures++;
            $display("FAIL reset_anodes got=%h exp=%h", anodes, 4'hF);
        end
        checks++;
        if (digit !== 4'h0) begin
            failures++;
            $display("FAIL reset_digit got=%h exp=%h", digit, 4'h0);
        end
        tick();
        checks++;
        if (anodes !== 4'hF) begin
            failures++;
            $display("FAIL first_cycle_dark got=%h exp=%h", anodes, 4'hF);
        end
    endtask

    task automatic test_scan();
        logic [3:0] dig_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        int slot, phase;
        logic [3:0] exp_an;
        do_reset();
        pulse_load(16'h1234);
        checks++;
        if (digit !== 4'h0 || anodes !== 4'hF) begin
            failures++;
            $display("FAIL scan_e1 got=%h/%h exp=0/f", digit, anodes);
        end
        while (edge_n < 32) begin
            tick();
            slot   = (edge_n - 1) / DIV;
            phase  = (edge_n - 1) % DIV;
            exp_an = (phase < BLK) ? 4'hF : an_tab[slot];
            checks++;
            if (anodes !== exp_an) begin
                failures++;
                $display("FAIL scan_anodes e=%0d got=%h exp=%h", edge_n, anodes, exp_an);
            end
            checks++;
            if (digit !== dig_tab[slot]) begin
                failures++;
                $display("FAIL scan_digit e=%0d got=%h exp=%h", edge_n, digit, dig_tab[slot]);
            end
        end
    endtask

    task automatic test_lead_zero();
        logic [15:0] vals     [2]    = '{16'h0050, 16'h0000};
        logic [3:0]  lit_mask [2]    = '{4'b0011, 4'b0001};
        logic [3:0]  digs     [2][4] = '{'{4'h0, 4'h5, 4'h0, 4'h0}, '{4'h0, 4'h0, 4'h0, 4'h0}};
        int slot, phase;
        logic [3:0] exp_an;
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            pulse_load(vals[v]);
            while (edge_n < 32) begin
                tick();
                slot   = (edge_n - 1) / DIV;
                phase  = (edge_n - 1) % DIV;
                exp_an = (phase < BLK || !lit_mask[v][slot]) ? 4'hF : an_tab[slot];
                checks++;
                if (anodes !== exp_an) begin
                    failures++;
                    $display("FAIL lz_anodes v=%0d e=%0d got=%h exp=%h", v, edge_n, anodes, exp_an);
                end
                if (exp_an != 4'hF) begin
                    checks++;
                    if (digit !== digs[v][slot]) begin
                        failures++;
                        $display("FAIL lz_digit v=%0d e=%0d got=%h exp=%h", v, edge_n, digit, digs[v][slot]);
                    end
                end
            end
        end
        // Position 2 of 0x0050 is lead-blanked; dropping blank_lz lights it on the next edge.
        do_reset();
        pulse_load(16'h0050);
        while (edge_n < 20) tick();
        checks++;
        if (anodes !== 4'hF) begin
            failures++;
            $display("FAIL lz_toggle_before got=%h exp=%h", anodes, 4'hF);
        end
        blank_lz = 1'b0;
        tick();
        checks++;
        if (anodes !== 4'b1011) begin
            failures++;
            $display("FAIL lz_toggle_after got=%h exp=%h", anodes, 4'b1011);
        end
    endtask

    task automatic test_mid_load();
        do_reset();
        pulse_load(16'h1234);
        while (edge_n < 19) tick();
        pulse_load(16'hABCD);
        checks++;
        if (digit !== 4'h2 || anodes !== 4'b1011) begin
            failures++;
            $display("FAIL midload_same_edge got=%h/%h exp=2/b", digit, anodes);
        end
        tick();
        checks++;
        if (digit !== 4'hB || anodes !== 4'b1011) begin
            failures++;
            $display("FAIL midload_new_digit got=%h/%h exp=b/b", digit, anodes);
        end
        while (edge_n < 24) tick();
        checks++;
        if (digit !== 4'hB || anodes !== 4'b1011) begin
            failures++;
            $display("FAIL midload_slot_end got=%h/%h exp=b/b", digit, anodes);
        end
        tick();
        checks++;
        if (digit !== 4'hA || anodes !== 4'hF) begin
            failures++;
            $display("FAIL midload_next_gap got=%h/%h exp=a/f", digit, anodes);
        end
        tick();
        tick();
        checks++;
        if (digit !== 4'hA || anodes !== 4'b0111) begin
            failures++;
            $display("FAIL midload_next_lit got=%h/%h exp=a/7", digit, anodes);
        end
    endtask

    task automatic test_wrap_load();
        do_reset();
        pulse_load(16'h1234);
        while (edge_n < 31) tick();
        pulse_load(16'h5678);
        checks++;
        if (digit !== 4'h1 || anodes !== 4'b0111) begin
            failures++;
            $display("FAIL wrapload_edge got=%h/%h exp=1/7", digit, anodes);
        end
        tick();
        checks++;
        if (digit !== 4'h8 || anodes !== 4'hF) begin
            failures++;
            $display("FAIL wrapload_pos0 got=%h/%h exp=8/f", digit, anodes);
        end
        tick();
        tick();
        checks++;
        if (digit !== 4'h8 || anodes !== 4'b1110) begin
            failures++;
            $display("FAIL wrapload_lit got=%h/%h exp=8/e", digit, anodes);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_an;
        do_reset();
        pulse_load(16'h1234);
        while (edge_n < 20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (digit !== 4'h0 || anodes !== 4'hF) begin
            failures++;
            $display("FAIL midrst_edge got=%h/%h exp=0/f", digit, anodes);
        end
        // Shadow was cleared, so position 0 shows 0 for a full 8-cycle slot.
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_an = (k <= 2 || k >= 9) ? 4'hF : 4'b1110;
            checks++;
            if (anodes !== exp_an) begin
                failures++;
                $display("FAIL midrst_anodes k=%0d got=%h exp=%h", k, anodes, exp_an);
            end
            checks++;
            if (digit !== 4'h0) begin
                failures++;
                $display("FAIL midrst_digit k=%0d got=%h exp=%h", k, digit, 4'h0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        value    = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_lead_zero();
        test_mid_load();
        test_wrap_load();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
